// File: rtl/sdram_write_if.sv
// Bundle of the write engine's SDRAM command bus, FIFO port and control
// handshake. master = the write engine, slave = the controller/FIFO side.
// Optional macro: SDRAM_WRITE_MASK_EN adds the fifo_mask byte-mask signal.
interface sdram_write_if;
  logic [2:0]  command;
  logic [11:0] address;
  logic [1:0]  bank;
  logic [15:0] data_out;
  logic [1:0]  data_mask;
  logic        enable;
  logic        idle;
  logic        auto_refresh;
  logic [21:0] app_address;
  logic [31:0] fifo_data;
  logic        fifo_read;
  logic        fifo_empty;
  logic        fifo_almost_empty;
`ifdef SDRAM_WRITE_MASK_EN
  logic [3:0]  fifo_mask;
`endif

  modport master (
    output command, address, bank, data_out, data_mask, idle, fifo_read,
    input  enable, auto_refresh, app_address, fifo_data, fifo_empty,
           fifo_almost_empty
`ifdef SDRAM_WRITE_MASK_EN
    , input fifo_mask
`endif
  );

  modport slave (
    input  command, address, bank, data_out, data_mask, idle, fifo_read,
    output enable, auto_refresh, app_address, fifo_data, fifo_empty,
           fifo_almost_empty
`ifdef SDRAM_WRITE_MASK_EN
    , output fifo_mask
`endif
  );
endinterface

// File: rtl/sdram_write.sv
// SDRAM write-path engine: drains 32-bit FWFT FIFO words as gapless
// top/bottom halfword full-page bursts, terminating on FIFO low, enable drop,
// refresh request or page end, and resuming at the next halfword address.
// Optional macro: SDRAM_WRITE_MASK_EN drives data_mask from fifo_mask;
// without it data_mask stays 2'b00.
module sdram_write #(
  parameter int T_RCD = 2,
  parameter int T_WR  = 2,
  parameter int T_RP  = 2
) (
  input logic          clk,
  input logic          rst,
  sdram_write_if.master bus
);
  // {RAS_n, CAS_n, WE_n} encodings
  localparam logic [2:0] CMD_NOP   = 3'b111;
  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_TERM  = 3'b110;
  localparam logic [2:0] CMD_PRE   = 3'b010;

  localparam int DW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_ACTIVATE, S_WRITE_CMD, S_WRITE_TOP,
    S_WRITE_BOTTOM, S_TERMINATE, S_PRECHARGE, S_WAIT
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] delay, delay_nx;
  logic [21:0]   wr_addr, wr_addr_nx;
  logic [2:0]    cmd_nx;
  logic [11:0]   addr_nx;
  logic [1:0]    bank_nx;
  logic [15:0]   dq_nx;
  logic [1:0]    dqm_nx;
  logic [1:0]    mask_top, mask_bot;
  logic          busy;
  logic          last_word;

  assign busy = (delay != '0);

`ifdef SDRAM_WRITE_MASK_EN
  assign mask_top = bus.fifo_mask[3:2];
  assign mask_bot = bus.fifo_mask[1:0];
`else
  assign mask_top = 2'b00;
  assign mask_bot = 2'b00;
`endif

  // the halfword being finished is the last one of the current burst
  assign last_word = bus.fifo_almost_empty | ~bus.enable | bus.auto_refresh |
                     ((wr_addr[7:0] + 8'd2) == 8'h00);

  assign bus.idle = ~busy && (state == S_IDLE);

  // Pop is combinational so the FWFT head advances on the same edge that
  // captures the bottom half; the following WRITE_TOP then sees the next word.
  assign bus.fifo_read = ~busy && (state == S_WRITE_BOTTOM);

  // state and registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      delay         <= '0;
      wr_addr       <= '0;
      bus.command   <= CMD_NOP;
      bus.address   <= '0;
      bus.bank      <= '0;
      bus.data_out  <= '0;
      bus.data_mask <= '0;
    end else begin
      state         <= state_nx;
      delay         <= delay_nx;
      wr_addr       <= wr_addr_nx;
      bus.command   <= cmd_nx;
      bus.address   <= addr_nx;
      bus.bank      <= bank_nx;
      bus.data_out  <= dq_nx;
      bus.data_mask <= dqm_nx;
    end
  end

  // next state, timing counter and write address
  always_comb begin
    state_nx   = state;
    delay_nx   = delay;
    wr_addr_nx = wr_addr;
    if (busy) begin
      delay_nx = delay - 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          wr_addr_nx = bus.app_address;
          if (bus.enable & ~bus.fifo_empty & ~bus.auto_refresh)
            state_nx = S_ACTIVATE;
        end
        S_ACTIVATE: begin
          delay_nx = DW'(T_RCD - 1);
          state_nx = S_WRITE_CMD;
        end
        S_WRITE_CMD: state_nx = S_WRITE_BOTTOM;
        S_WRITE_TOP: state_nx = S_WRITE_BOTTOM;
        S_WRITE_BOTTOM: begin
          // carries past the column into row/bank; bank 3 top wraps to 0
          wr_addr_nx = wr_addr + 22'd2;
          state_nx   = last_word ? S_TERMINATE : S_WRITE_TOP;
        end
        S_TERMINATE: begin
          delay_nx = DW'(T_WR);
          state_nx = S_PRECHARGE;
        end
        S_PRECHARGE: begin
          delay_nx = DW'(T_RP);
          state_nx = S_WAIT;
        end
        S_WAIT: begin
          if (~bus.enable)
            state_nx = S_IDLE;
          else if (~bus.auto_refresh & ~bus.fifo_empty)
            state_nx = S_ACTIVATE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // next bus outputs; address/bank/data hold when not driven, mask defaults clear
  always_comb begin
    cmd_nx  = CMD_NOP;
    addr_nx = bus.address;
    bank_nx = bus.bank;
    dq_nx   = bus.data_out;
    dqm_nx  = 2'b00;
    if (!busy) begin
      case (state)
        S_ACTIVATE: begin
          cmd_nx  = CMD_ACT;
          addr_nx = wr_addr[19:8];
          bank_nx = wr_addr[21:20];
        end
        S_WRITE_CMD: begin
          cmd_nx  = CMD_WRITE;
          addr_nx = {4'h0, wr_addr[7:0]};
          dq_nx   = bus.fifo_data[31:16];
          dqm_nx  = mask_top;
        end
        S_WRITE_TOP: begin
          dq_nx  = bus.fifo_data[31:16];
          dqm_nx = mask_top;
        end
        S_WRITE_BOTTOM: begin
          dq_nx  = bus.fifo_data[15:0];
          dqm_nx = mask_bot;
        end
        // A10 still low from the WRITE column: precharge only the open bank
        S_TERMINATE: cmd_nx = CMD_TERM;
        S_PRECHARGE: cmd_nx = CMD_PRE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_write.sv
// Bench for sdram_write: an FWFT FIFO model feeds random words; a bus monitor
// decodes ACT/WRITE/TERM/PRE into a halfword memory image that is compared
// against the address/word list the words should land at.
module tb_sdram_write;
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_WRITE = 3'b100,
                         C_TERM = 3'b110, C_PRE = 3'b010;

  typedef struct { logic [31:0] d; logic [3:0] m; } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_write_if bus();
  sdram_write dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // FIFO model
  word_t fq[$];
  word_t src[$];
  word_t exp_q[$];
  bit    preload = 1'b0;
  bit    rd_seen = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rd_seen && fq.size() > 0) void'(fq.pop_front());
    while (src.size() > 0 && (preload || $urandom_range(0, 3) == 0)) begin
      fq.push_back(src.pop_front());
      if (!preload) break;
    end
    bus.fifo_empty        = (fq.size() == 0);
    bus.fifo_almost_empty = (fq.size() <= 1);
    bus.fifo_data         = (fq.size() > 0) ? fq[0].d : $urandom;
`ifdef SDRAM_WRITE_MASK_EN
    bus.fifo_mask         = (fq.size() > 0) ? fq[0].m : 4'($urandom);
`endif
  end

  // bus monitor
  int cyc = 0;
  int n_act, n_write, n_term, n_pre, n_rd;
  int proto_err, rcd_err, twr_err, rp_err, ar_err, wrap_err, odd_err, dqm_err;
  int act_cyc, term_cyc, pre_cyc, idle_cyc, beats;
  bit burst = 1'b0;
  logic [7:0]  col;
  logic [11:0] cur_row;
  logic [1:0]  cur_bank;
  logic        ar_d1 = 1'b0, ar_d2 = 1'b0;
  logic [11:0] act_row[$];
  logic [1:0]  act_bank[$];
  logic [7:0]  wr_col[$];
  logic [15:0] mem[int];
  logic [1:0]  mem_m[int];

  task automatic put_beat();
    int a;
    a = int'({cur_bank, cur_row, col});
    mem[a]   = bus.data_out;
    mem_m[a] = bus.data_mask;
  endtask

  task automatic clr_stats();
    n_act = 0; n_write = 0; n_term = 0; n_pre = 0; n_rd = 0;
    proto_err = 0; rcd_err = 0; twr_err = 0; rp_err = 0; ar_err = 0;
    wrap_err = 0; odd_err = 0; dqm_err = 0;
    act_cyc = -100; term_cyc = -100; pre_cyc = -1; idle_cyc = -1;
    act_row.delete(); act_bank.delete(); wr_col.delete();
    mem.delete(); mem_m.delete();
  endtask

  always @(negedge clk) begin
    rd_seen = bus.fifo_read;
    cyc++;
    if (rst) begin
      burst = 1'b0;
    end else begin
      if (bus.fifo_read) n_rd++;
      if (burst) begin
        if (bus.command == C_NOP) begin
          if (col == 8'hFF) wrap_err++;
          col++;
          beats++;
          put_beat();
        end else if (bus.command == C_TERM) begin
          burst = 1'b0;
          n_term++;
          term_cyc = cyc;
          if (beats % 2 != 0) odd_err++;
          if (bus.data_mask != 2'b00) dqm_err++;
        end else proto_err++;
      end else begin
        case (bus.command)
          C_ACT: begin
            n_act++;
            act_cyc  = cyc;
            cur_row  = bus.address;
            cur_bank = bus.bank;
            act_row.push_back(bus.address);
            act_bank.push_back(bus.bank);
            if (ar_d2) ar_err++;
            if (pre_cyc >= 0 && cyc - pre_cyc < 3) rp_err++;
          end
          C_WRITE: begin
            n_write++;
            if (cyc - act_cyc != 2) rcd_err++;
            if (bus.address[11:8] != 4'h0 || bus.bank != cur_bank) proto_err++;
            col   = bus.address[7:0];
            beats = 1;
            burst = 1'b1;
            wr_col.push_back(col);
            put_beat();
          end
          C_PRE: begin
            n_pre++;
            if (cyc - term_cyc != 3) twr_err++;
            pre_cyc = cyc;
          end
          C_NOP: ;
          default: proto_err++;
        endcase
        if (!burst && bus.data_mask != 2'b00) dqm_err++;
      end
      if (idle_cyc < 0 && pre_cyc >= 0 && bus.idle) idle_cyc = cyc;
    end
    ar_d2 = ar_d1;
    ar_d1 = bus.auto_refresh;
  end

  int hold_rd, hold_act, hold_term;

  task automatic fill(input int n);
    word_t w;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      w.d = $urandom;
      w.m = 4'($urandom_range(0, 15));
      exp_q.push_back(w);
    end
  endtask

  task automatic check_mem(input string tag, input logic [21:0] start);
    logic [21:0] a;
    chk({tag, ".nwr"}, mem.size(), 2 * exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      a = start + 22'(2 * k);
      chk({tag, ".hi"}, mem.exists(int'(a)) ? {16'h0, mem[int'(a)]} : 32'hBAD0_0000,
          {16'h0, exp_q[k].d[31:16]});
      chk({tag, ".lo"}, mem.exists(int'(a + 22'd1)) ? {16'h0, mem[int'(a + 22'd1)]} : 32'hBAD0_0000,
          {16'h0, exp_q[k].d[15:0]});
`ifdef SDRAM_WRITE_MASK_EN
      chk({tag, ".mhi"}, mem_m.exists(int'(a)) ? {30'h0, mem_m[int'(a)]} : 32'hBAD0_0000,
          {30'h0, exp_q[k].m[3:2]});
      chk({tag, ".mlo"}, mem_m.exists(int'(a + 22'd1)) ? {30'h0, mem_m[int'(a + 22'd1)]} : 32'hBAD0_0000,
          {30'h0, exp_q[k].m[1:0]});
`endif
    end
    chk({tag, ".proto"}, proto_err, 0);
    chk({tag, ".trcd"}, rcd_err, 0);
    chk({tag, ".twr"}, twr_err, 0);
    chk({tag, ".trp"}, rp_err, 0);
    chk({tag, ".ar_act"}, ar_err, 0);
    chk({tag, ".pagewrap"}, wrap_err, 0);
    chk({tag, ".oddburst"}, odd_err, 0);
    chk({tag, ".dqm_idle"}, dqm_err, 0);
    chk({tag, ".pops"}, n_rd, exp_q.size());
  endtask

  // run exp_q from start; ar_at>0 raises refresh for 20 cycles once that
  // many words have been popped, rnd_ar toggles refresh randomly
  task automatic run_scn(input string tag, input logic [21:0] start, input bit pl,
                         input bit rnd_ar, input int ar_at);
    int t;
    bit ar_done;
    clr_stats();
    preload = pl;
    foreach (exp_q[k]) src.push_back(exp_q[k]);
    @(posedge clk); #2;
    bus.app_address = start;
    bus.enable      = 1'b1;
    t = 0;
    ar_done = 1'b0;
    while (n_rd < exp_q.size() && t < 4000) begin
      @(posedge clk); #2;
      t++;
      if (rnd_ar && $urandom_range(0, 7) == 0) bus.auto_refresh = ~bus.auto_refresh;
      if (ar_at > 0 && !ar_done && n_rd >= ar_at) begin
        bus.auto_refresh = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        hold_rd = n_rd; hold_act = n_act; hold_term = n_term;
        bus.auto_refresh = 1'b0;
        ar_done = 1'b1;
      end
    end
    chk({tag, ".done"}, n_rd, exp_q.size());
    bus.enable       = 1'b0;
    bus.auto_refresh = 1'b0;
    t = 0;
    while (!bus.idle && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    chk({tag, ".idle"}, bus.idle, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    check_mem(tag, start);
  endtask

  initial begin
    int t;
    logic [21:0] st;
    bus.enable = 1'b0; bus.auto_refresh = 1'b0; bus.app_address = '0;
    bus.fifo_data = '0; bus.fifo_empty = 1'b1; bus.fifo_almost_empty = 1'b1;
`ifdef SDRAM_WRITE_MASK_EN
    bus.fifo_mask = '0;
`endif
    clr_stats();
    repeat (3) @(negedge clk);
    chk("rst.command", bus.command, C_NOP);
    chk("rst.address", bus.address, 12'h000);
    chk("rst.bank", bus.bank, 2'b00);
    chk("rst.data_out", bus.data_out, 16'h0000);
    chk("rst.data_mask", bus.data_mask, 2'b00);
    chk("rst.fifo_read", bus.fifo_read, 1'b0);
    chk("rst.idle", bus.idle, 1'b1);
    @(posedge clk); #2;
    rst = 1'b0;

    // single word
    fill(1);
    exp_q[0].d = 32'hDEADBEEF;
    exp_q[0].m = 4'b0110;
    run_scn("one", 22'h000010, 1'b1, 1'b0, 0);
    chk("one.nact", n_act, 1);
    chk("one.row", act_row.size() > 0 ? act_row[0] : 12'hFFF, 12'h000);
    chk("one.bank", act_bank.size() > 0 ? act_bank[0] : 2'b11, 2'b00);
    chk("one.nwrite", n_write, 1);
    chk("one.col", wr_col.size() > 0 ? wr_col[0] : 8'hFF, 8'h10);
    chk("one.nterm", n_term, 1);
    chk("one.npre", n_pre, 1);
    chk("one.idle_lat", idle_cyc - pre_cyc, 3);
`ifdef SDRAM_WRITE_MASK_EN
    chk("one.dqm_top", mem_m.exists(32'h10) ? mem_m[32'h10] : 2'bxx, 2'b01);
    chk("one.dqm_bot", mem_m.exists(32'h11) ? mem_m[32'h11] : 2'bxx, 2'b10);
`endif

    // four words from column 0: one burst
    fill(4);
    run_scn("four", {2'b10, 12'h123, 8'h00}, 1'b1, 1'b0, 0);
    chk("four.nact", n_act, 1);
    chk("four.nwrite", n_write, 1);
    chk("four.nterm", n_term, 1);

    // page end at column 0xFE: split and re-activate next row
    fill(4);
    run_scn("pgend", {2'b01, 12'h005, 8'hFC}, 1'b1, 1'b0, 0);
    chk("pgend.nact", n_act, 2);
    chk("pgend.nwrite", n_write, 2);
    chk("pgend.row2", act_row.size() > 1 ? act_row[1] : 12'hFFF, 12'h006);
    chk("pgend.col2", wr_col.size() > 1 ? wr_col[1] : 8'hFF, 8'h00);

    // top of bank 3 wraps to bank 0 row 0
    fill(2);
    run_scn("bkwrap", {2'b11, 12'hFFF, 8'hFE}, 1'b1, 1'b0, 0);
    chk("bkwrap.bank2", act_bank.size() > 1 ? act_bank[1] : 2'b11, 2'b00);
    chk("bkwrap.row2", act_row.size() > 1 ? act_row[1] : 12'hFFF, 12'h000);

    // refresh during burst: stop after current word, hold, resume next address
    fill(8);
    run_scn("aref", {2'b00, 12'h040, 8'h20}, 1'b1, 1'b0, 2);
    chk("aref.hold_rd", hold_rd, 3);
    chk("aref.hold_act", hold_act, 1);
    chk("aref.hold_term", hold_term, 1);
    chk("aref.nact", n_act, 2);
    chk("aref.col2", wr_col.size() > 1 ? wr_col[1] : 8'hFF, 8'h26);

    // reset while in WRITE_TOP
    clr_stats();
    fill(4);
    preload = 1'b1;
    foreach (exp_q[k]) src.push_back(exp_q[k]);
    @(posedge clk); #2;
    bus.app_address = 22'h000100;
    bus.enable = 1'b1;
    t = 0;
    while (n_write == 0 && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    chk("rstmid.write_seen", n_write, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.command", bus.command, C_NOP);
    chk("rstmid.idle", bus.idle, 1'b1);
    chk("rstmid.fifo_read", bus.fifo_read, 1'b0);
    bus.enable = 1'b0;
    src.delete();
    fq.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // random traffic: trickle or preloaded FIFO, random refresh
    for (int i = 0; i < 8; i++) begin
      fill($urandom_range(1, 16));
      st = 22'($urandom) & 22'h3FFFFE;
      run_scn($sformatf("rnd%0d", i), st, 1'($urandom_range(0, 1)), 1'b1, 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
